// File: rtl/timer_pkg.sv
// Shared constants for the timer capture/compare block: default sizing,
// cause bit positions and the overflow-handshake FSM encoding.
package timer_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RETRY = 15;

  localparam int unsigned CAUSE_OVF = 0;
  localparam int unsigned CAUSE_CMP = 1;
  localparam int unsigned CAUSE_CAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } ovf_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe followed by a rising-edge
// detector; o_rise is high for one cycle per synchronised low-to-high change.
module sync_edge (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = i_d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign o_rise = s2_q & ~s3_q;

endmodule

// File: rtl/timer_capcomp.sv
// Capture/compare companion for timer32b: overflow clear handshake with retry,
// edge-qualified compare match, synchronised external capture, sticky causes.
module timer_capcomp #(
  parameter int unsigned WIDTH = timer_pkg::WIDTH,
  parameter int unsigned RETRY = timer_pkg::RETRY
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_currentv,
  input  logic             i_overflow,
  output logic             o_clearw,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] i_cmp_value,
  input  logic             i_cmp_load,
  input  logic [2:0]       i_ack,
  input  logic [2:0]       i_irq_en,
  output logic [2:0]       o_cause,
  output logic             o_irq,
  output logic [WIDTH-1:0] o_captured,
  output logic             o_overrun
);
  import timer_pkg::*;

  localparam int unsigned CW = (RETRY < 2) ? 1 : $clog2(RETRY);

  ovf_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clearw_q, clearw_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             prev_eq_q, prev_eq_d;
  logic [2:0]       cause_q, cause_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] captured_q, captured_d;

  logic       ovf_evt, cmp_evt, cap_evt, cap_rise, eq;
  logic [2:0] evt;

  sync_edge u_cap_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_capture),
    .o_rise  (cap_rise)
  );

  // Only the IDLE->CLEAR entry flags an overflow; retries re-pulse clearw only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_overflow) begin
          state_d = ST_CLEAR;
          ovf_evt = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_WAIT_LOW;
        cnt_d   = '0;
      end
      ST_WAIT_LOW: begin
        if (i_enable) begin
          if (!i_overflow) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(RETRY - 1)) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    clearw_d = (state_d == ST_CLEAR);
  end

  always_comb begin
    eq        = (i_currentv == cmp_q);
    cmp_evt   = i_enable & eq & ~prev_eq_q;
    prev_eq_d = i_cmp_load ? 1'b0 : eq;
    cmp_d     = i_cmp_load ? i_cmp_value : cmp_q;
  end

  // Events override a same-cycle ack; a capture onto a pending capture is an overrun.
  always_comb begin
    cap_evt             = i_enable & cap_rise;
    evt                 = '0;
    evt[CAUSE_OVF]      = ovf_evt;
    evt[CAUSE_CMP]      = cmp_evt;
    evt[CAUSE_CAP]      = cap_evt;
    cause_d             = (cause_q & ~i_ack) | evt;
    overrun_d           = (overrun_q & ~i_ack[CAUSE_CAP]) | (cap_evt & cause_q[CAUSE_CAP]);
    captured_d          = (cap_evt && !cause_q[CAUSE_CAP]) ? i_currentv : captured_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clearw_q   <= 1'b0;
      cmp_q      <= '1;
      prev_eq_q  <= 1'b0;
      cause_q    <= '0;
      overrun_q  <= 1'b0;
      captured_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clearw_q   <= clearw_d;
      cmp_q      <= cmp_d;
      prev_eq_q  <= prev_eq_d;
      cause_q    <= cause_d;
      overrun_q  <= overrun_d;
      captured_q <= captured_d;
    end
  end

  assign o_clearw   = clearw_q;
  assign o_cause    = cause_q;
  assign o_irq      = |(cause_q & i_irq_en);
  assign o_captured = captured_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_timer_capcomp.sv
// Bench for timer_capcomp: directed scenarios plus randomized traffic, every
// cycle scored against a behavioural model through an expectation queue.
module tb_timer_capcomp;

  localparam int unsigned W  = 32;
  localparam int unsigned RT = 15;

  logic          clk = 1'b0;
  logic          i_reset, i_enable, i_overflow, i_capture, i_cmp_load;
  logic [W-1:0]  i_currentv, i_cmp_value;
  logic [2:0]    i_ack, i_irq_en;
  logic          o_clearw, o_irq, o_overrun;
  logic [2:0]    o_cause;
  logic [W-1:0]  o_captured;

  timer_capcomp #(.WIDTH(W), .RETRY(RT)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_currentv(i_currentv), .i_overflow(i_overflow), .o_clearw(o_clearw),
    .i_capture(i_capture), .i_cmp_value(i_cmp_value), .i_cmp_load(i_cmp_load),
    .i_ack(i_ack), .i_irq_en(i_irq_en), .o_cause(o_cause), .o_irq(o_irq),
    .o_captured(o_captured), .o_overrun(o_overrun)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic         clearw;
    logic [2:0]   cause;
    logic         irq;
    logic [W-1:0] captured;
    logic         overrun;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: episode/run-length view of the overflow handshake,
  // first-cycle-of-equality compare, capture on the third high sample.
  bit           m_in_episode, m_clear;
  int unsigned  m_high_run;
  logic [W-1:0] m_cmp;
  bit           m_was_equal;
  bit           samp[3];
  logic [2:0]   m_cause;
  bit           m_ovr;
  logic [W-1:0] m_cap;

  task automatic model_reset();
    m_in_episode = 0; m_clear = 0; m_high_run = 0;
    m_cmp = {W{1'b1}}; m_was_equal = 0;
    samp[0] = 0; samp[1] = 0; samp[2] = 0;
    m_cause = 3'b000; m_ovr = 0; m_cap = '0;
  endtask

  task automatic tick();
    exp_t       e;
    logic [2:0] ev;
    bit         clear_next, equal, first_high;
    if (!i_reset) model_reset();
    else begin
      ev = 3'b000;
      clear_next = 0;
      if (m_clear) begin
        m_in_episode = 1;
        m_high_run = 0;
      end else if (!m_in_episode) begin
        if (i_enable && i_overflow) begin
          clear_next = 1;
          ev[0] = 1'b1;
        end
      end else if (i_enable) begin
        if (!i_overflow) begin
          m_in_episode = 0;
          m_high_run = 0;
        end else begin
          m_high_run++;
          if (m_high_run == RT) begin
            clear_next = 1;
            m_high_run = 0;
          end
        end
      end
      m_clear = clear_next;

      equal = (i_currentv == m_cmp);
      ev[1] = i_enable && equal && !m_was_equal;
      m_was_equal = i_cmp_load ? 1'b0 : equal;
      if (i_cmp_load) m_cmp = i_cmp_value;

      first_high = samp[1] && !samp[0];
      ev[2] = i_enable && first_high;
      samp[0] = samp[1]; samp[1] = samp[2]; samp[2] = i_capture;

      if (ev[2] && m_cause[2]) m_ovr = 1;
      else if (i_ack[2]) m_ovr = 0;
      if (ev[2] && !m_cause[2]) m_cap = i_currentv;
      m_cause = (m_cause & ~i_ack) | ev;
    end
    e.clearw = m_clear; e.cause = m_cause; e.irq = |(m_cause & i_irq_en);
    e.captured = m_cap; e.overrun = m_ovr;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_clearw",   32'(o_clearw),  32'(e.clearw));
        chk("sb_cause",    32'(o_cause),   32'(e.cause));
        chk("sb_irq",      32'(o_irq),     32'(e.irq));
        chk("sb_captured", o_captured,     e.captured);
        chk("sb_overrun",  32'(o_overrun), 32'(e.overrun));
      end
    end
  end

  task automatic ack_all();
    i_ack = 3'b111; tick(); i_ack = 3'b000;
  endtask

  initial begin : stim
    int pulses, first, rises;
    logic [W-1:0] at_val;
    bit prev;
    i_reset = 0; i_enable = 1; i_overflow = 0; i_capture = 0; i_cmp_load = 0;
    i_currentv = '0; i_cmp_value = '0; i_ack = 3'b000; i_irq_en = 3'b000;
    model_reset();
    tick(); tick();
    chk("reset_cause", 32'(o_cause), 32'd0);
    chk("reset_clearw", 32'(o_clearw), 32'd0);
    i_reset = 1;

    // compare register resets to all-ones
    i_currentv = {W{1'b1}}; tick();
    chk("cmp_reset_ones", 32'(o_cause[1]), 32'd1);
    i_currentv = '0; ack_all();
    chk("ack_all_clears", 32'(o_cause), 32'd0);

    // single overflow
    i_irq_en = 3'b001;
    for (int i = 0; i < 10; i++) tick();
    i_overflow = 1; tick();
    chk("ovf_clearw_hi", 32'(o_clearw), 32'd1);
    chk("ovf_cause0", 32'(o_cause[0]), 32'd1);
    chk("ovf_irq", 32'(o_irq), 32'd1);
    tick();
    chk("ovf_clearw_once", 32'(o_clearw), 32'd0);
    i_overflow = 0; tick(); tick();
    ack_all();

    // stuck overflow
    i_overflow = 1; pulses = 0; first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_clearw) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("stuck_pulses", 32'(pulses), 32'd3);
    chk("stuck_first", 32'(first), 32'd1);
    i_overflow = 0; tick(); tick(); ack_all();

    // compare match, once only
    i_irq_en = 3'b010;
    i_currentv = 32'h60; i_cmp_value = 32'h64; i_cmp_load = 1; tick(); i_cmp_load = 0;
    rises = 0; at_val = '0;
    for (int unsigned k = 32'h61; k <= 32'h70; k++) begin
      i_currentv = k; prev = o_cause[1]; tick();
      if (!prev && o_cause[1]) begin rises++; at_val = k; end
    end
    chk("cmp_rises", 32'(rises), 32'd1);
    chk("cmp_at", at_val, 32'h64);
    chk("cmp_irq", 32'(o_irq), 32'd1);
    i_ack = 3'b010; tick(); i_ack = 3'b000;
    chk("cmp_ack", 32'(o_cause[1]), 32'd0);
    i_cmp_value = 32'h70; i_cmp_load = 1; tick(); i_cmp_load = 0;
    tick();
    chk("cmp_load_rearm", 32'(o_cause[1]), 32'd1);
    ack_all();

    // match and ack in the same cycle
    i_currentv = 32'h1FF; i_cmp_value = 32'h200; i_cmp_load = 1; tick(); i_cmp_load = 0;
    i_currentv = 32'h200; i_ack = 3'b010; tick(); i_ack = 3'b000;
    chk("evt_beats_ack", 32'(o_cause[1]), 32'd1);
    ack_all();

    // capture, held high, then overrun
    i_currentv = 32'h100; i_capture = 1; tick();
    i_currentv = 32'h101; tick();
    i_currentv = 32'h102; tick();
    chk("cap_value", o_captured, 32'h102);
    chk("cap_cause", 32'(o_cause[2]), 32'd1);
    for (int i = 0; i < 3; i++) begin i_currentv++; tick(); end
    chk("cap_held_once", 32'(o_overrun), 32'd0);
    i_capture = 0; tick(); tick(); tick();
    i_capture = 1; i_currentv = 32'h200;
    for (int i = 0; i < 4; i++) tick();
    chk("ovr_set", 32'(o_overrun), 32'd1);
    chk("ovr_keep_value", o_captured, 32'h102);
    i_capture = 0; tick(); tick();
    i_ack = 3'b100; tick(); i_ack = 3'b000;
    chk("ovr_ack", 32'(o_overrun), 32'd0);
    chk("cap_ack", 32'(o_cause[2]), 32'd0);

    // asynchronous reset in WAIT_LOW
    i_irq_en = 3'b111;
    i_overflow = 1; tick(); tick(); tick();
    #2 i_reset = 0;
    #1;
    chk("arst_clearw", 32'(o_clearw), 32'd0);
    chk("arst_cause", 32'(o_cause), 32'd0);
    chk("arst_irq", 32'(o_irq), 32'd0);
    chk("arst_overrun", 32'(o_overrun), 32'd0);
    chk("arst_captured", o_captured, 32'd0);
    tick();
    i_reset = 1; tick();
    chk("arst_restart", 32'(o_clearw), 32'd1);
    tick();
    chk("arst_restart_once", 32'(o_clearw), 32'd0);
    i_overflow = 0; tick(); ack_all();

    // randomized traffic, scored every cycle
    for (int n = 0; n < 2500; n++) begin
      i_reset  = ($urandom_range(0, 499) != 0);
      i_enable = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 59))
        0:       i_currentv = $urandom();
        1:       i_currentv = {W{1'b1}} - W'($urandom_range(0, 3));
        2, 3:    i_currentv = i_cmp_value;
        4, 5, 6: ;
        default: i_currentv = i_currentv + 1;
      endcase
      if ($urandom_range(0, 7) == 0) i_overflow = ~i_overflow;
      if ($urandom_range(0, 3) == 0) i_capture = ~i_capture;
      i_cmp_load = ($urandom_range(0, 15) == 0);
      if (i_cmp_load) i_cmp_value = i_currentv + W'($urandom_range(0, 4));
      i_ack = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 31) == 0) i_irq_en = 3'($urandom_range(0, 7));
      tick();
    end
    i_reset = 1;
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
